// File: rtl/spi_regbank_pkg.sv
// Shared definitions for the SPI register bank: address-width helper,
// error-flag placement and the address-decode region type.
package spi_regbank_pkg;

  localparam int ERR_BIT_OFS = 1;

  typedef enum logic [2:0] {
    REG_CFG,
    REG_STATUS,
    REG_FLG,
    REG_MSK,
    REG_INVALID
  } region_e;

  // The map holds the config and status registers plus the flag and mask registers
  function automatic int regbank_addr_w(input int num_cfg, input int num_status);
    return $clog2(num_cfg + num_status + 2);
  endfunction

endpackage

// File: rtl/spi_regbank_evt.sv
// Event block: rising-edge capture into sticky W1C flags, mask register
// and a registered interrupt. Flag sets take priority over a same-cycle clear.
module spi_regbank_evt
  import spi_regbank_pkg::*;
#(
  parameter int NUM_EVT   = 4,
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_EVT-1:0]   event_i,
  input  logic                 flg_we_i,
  input  logic                 msk_we_i,
  input  logic                 err_set_i,
  input  logic [REG_WIDTH-1:0] wdata_i,
  output logic [REG_WIDTH-1:0] flags_o,
  output logic [REG_WIDTH-1:0] mask_o,
  output logic                 irq_o
);

  localparam int ERR_BIT = REG_WIDTH - ERR_BIT_OFS;
  localparam logic [REG_WIDTH-1:0] IMPL =
    (REG_WIDTH'(1) << ERR_BIT) | ((REG_WIDTH'(1) << NUM_EVT) - REG_WIDTH'(1));

  logic [NUM_EVT-1:0]   hist_q;
  logic [REG_WIDTH-1:0] flags_q, flags_d;
  logic [REG_WIDTH-1:0] mask_q, mask_d;
  logic                 irq_q, irq_d;
  logic [REG_WIDTH-1:0] set_vec;

  genvar gi;
  generate
    for (gi = 0; gi < REG_WIDTH; gi++) begin : g_set
      if (gi < NUM_EVT) begin : g_evt
        assign set_vec[gi] = event_i[gi] & ~hist_q[gi];
      end else if (gi == ERR_BIT) begin : g_err
        assign set_vec[gi] = err_set_i;
      end else begin : g_zero
        assign set_vec[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    flags_d = (flags_q & ~(flg_we_i ? wdata_i : '0)) | set_vec;
    mask_d  = msk_we_i ? (wdata_i & IMPL) : mask_q;
    // irq follows the flag/mask state one cycle later
    irq_d   = |(flags_q & mask_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      hist_q  <= event_i;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign flags_o = flags_q;
  assign mask_o  = mask_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/spi_regbank.sv
// Parametrised register bank behind the SPI register-access interface:
// config array with per-bit write masks, live status, event block, registered reads.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 4,
  parameter int REG_WIDTH  = 8,
  parameter int NUM_EVT    = 4,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_WMASK = '1,
  parameter int ADDR_W     = regbank_addr_w(NUM_CFG, NUM_STATUS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [REG_WIDTH-1:0]            wdata,
  input  logic                            we,
  input  logic                            re,
  output logic [REG_WIDTH-1:0]            rdata,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  input  logic [NUM_EVT-1:0]              event_in,
  output logic                            irq
);

  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NUM_CFG);
  localparam logic [ADDR_W-1:0] A_FLG  = ADDR_W'(NUM_CFG + NUM_STATUS);
  localparam logic [ADDR_W-1:0] A_MSK  = ADDR_W'(NUM_CFG + NUM_STATUS + 1);

  region_e                      region;
  logic                         acc_we, acc_re, addr_err;
  logic [NUM_CFG*REG_WIDTH-1:0] cfg_q, cfg_d;
  logic [REG_WIDTH-1:0]         rdata_q, rdata_d, rd_val;
  logic [REG_WIDTH-1:0]         flags, mask;

  always_comb begin
    if (addr < A_STAT)      region = REG_CFG;
    else if (addr < A_FLG)  region = REG_STATUS;
    else if (addr == A_FLG) region = REG_FLG;
    else if (addr == A_MSK) region = REG_MSK;
    else                    region = REG_INVALID;
  end

  assign acc_we   = ena & we;
  assign acc_re   = ena & re;
  assign addr_err = (acc_we && (region == REG_STATUS || region == REG_INVALID)) ||
                    (acc_re && region == REG_INVALID);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
      localparam logic [REG_WIDTH-1:0] WM = CFG_WMASK[gi*REG_WIDTH +: REG_WIDTH];
      logic hit;
      assign hit = acc_we && (region == REG_CFG) && (addr == ADDR_W'(gi));
      // Non-writable bits keep whatever reset loaded into them
      assign cfg_d[gi*REG_WIDTH +: REG_WIDTH] = hit ?
        ((wdata & WM) | (cfg_q[gi*REG_WIDTH +: REG_WIDTH] & ~WM)) :
        cfg_q[gi*REG_WIDTH +: REG_WIDTH];
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (region)
      REG_CFG: begin
        for (int i = 0; i < NUM_CFG; i++)
          if (addr == ADDR_W'(i)) rd_val = cfg_q[i*REG_WIDTH +: REG_WIDTH];
      end
      REG_STATUS: begin
        for (int j = 0; j < NUM_STATUS; j++)
          if (addr == ADDR_W'(NUM_CFG + j)) rd_val = status_regs[j*REG_WIDTH +: REG_WIDTH];
      end
      REG_FLG: rd_val = flags;
      REG_MSK: rd_val = mask;
      default: rd_val = '0;
    endcase
  end

  assign rdata_d = acc_re ? rd_val : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= CFG_RESET;
      rdata_q <= '0;
    end else begin
      cfg_q   <= cfg_d;
      rdata_q <= rdata_d;
    end
  end

  spi_regbank_evt #(
    .NUM_EVT   (NUM_EVT),
    .REG_WIDTH (REG_WIDTH)
  ) u_evt (
    .clk       (clk),
    .rst       (rst),
    .event_i   (event_in),
    .flg_we_i  (acc_we && region == REG_FLG),
    .msk_we_i  (acc_we && region == REG_MSK),
    .err_set_i (addr_err),
    .wdata_i   (wdata),
    .flags_o   (flags),
    .mask_o    (mask),
    .irq_o     (irq)
  );

  assign rdata       = rdata_q;
  assign config_regs = cfg_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: directed vector table for the documented
// corner cases, then randomized traffic against a behavioural model.
module tb_spi_regbank;

  localparam int NC = 8, NS = 4, RW = 8, NE = 4, AW = 4;
  localparam logic [NC*RW-1:0] CRST = 64'h0000_0000_0050_A500;
  localparam logic [NC*RW-1:0] CWM  = 64'hFFFF_FFFF_FF0F_FFFF;

  logic           clk = 1'b0, rst = 1'b1, ena = 1'b0, we = 1'b0, re = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [RW-1:0]  wdata = '0;
  logic [RW-1:0]  rdata;
  logic [NC*RW-1:0] config_regs;
  logic [NS*RW-1:0] status_regs = 32'hD4_7E_3C_11;
  logic [NE-1:0]  event_in = '0;
  logic           irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_regbank #(
    .NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(RW), .NUM_EVT(NE),
    .CFG_RESET(CRST), .CFG_WMASK(CWM)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .config_regs(config_regs), .status_regs(status_regs),
    .event_in(event_in), .irq(irq)
  );

  typedef struct {
    logic          en, w, r;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    logic [NE-1:0] ev;
    logic [RW-1:0] ex_rd;
    logic          ex_irq;
  } vec_t;

  vec_t tbl[38];

  function automatic vec_t mk(logic en, logic w, logic r, logic [AW-1:0] a, logic [RW-1:0] d,
                              logic [NE-1:0] ev, logic [RW-1:0] ex_rd, logic ex_irq);
    vec_t v;
    v.en = en; v.w = w; v.r = r; v.a = a; v.d = d; v.ev = ev; v.ex_rd = ex_rd; v.ex_irq = ex_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, let the edge happen, sample 1 ns later
  task automatic apply(input logic en, input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [RW-1:0] d, input logic [NE-1:0] ev);
    ena = en; we = w; re = r; addr = a; wdata = d; event_in = ev;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  // Behavioural reference: register file as arrays, updated per the address map
  logic [RW-1:0] m_cfg[NC];
  logic [RW-1:0] m_flg, m_msk, m_rd;
  logic [NE-1:0] m_hist;
  logic          m_irq;

  function automatic logic [RW-1:0] wmask_of(int i);
    return (i == 2) ? 8'h0F : 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cfg[i] = (i == 1) ? 8'hA5 : (i == 2) ? 8'h50 : 8'h00;
    m_flg = '0; m_msk = '0; m_rd = '0; m_hist = '0; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic w, input logic r, input int a,
                            input logic [RW-1:0] d, input logic [NE-1:0] ev,
                            input logic [NS*RW-1:0] st);
    logic          err;
    logic          irq_next;
    logic [RW-1:0] rise;
    err = 1'b0;
    irq_next = |(m_flg & m_msk);
    if (en && r) begin
      if (a < NC)              m_rd = m_cfg[a];
      else if (a < NC + NS)    m_rd = st[(a - NC)*RW +: RW];
      else if (a == NC + NS)   m_rd = m_flg;
      else if (a == NC+NS+1)   m_rd = m_msk;
      else begin m_rd = 8'h00; err = 1'b1; end
    end
    if (en && w) begin
      if (a < NC)              m_cfg[a] = (d & wmask_of(a)) | (m_cfg[a] & ~wmask_of(a));
      else if (a < NC + NS)    err = 1'b1;
      else if (a == NC + NS)   m_flg = m_flg & ~d;
      else if (a == NC+NS+1)   m_msk = d & 8'h8F;
      else                     err = 1'b1;
    end
    rise = {4'b0, ev & ~m_hist};
    m_flg = m_flg | rise | (err ? 8'h80 : 8'h00);
    m_hist = ev;
    m_irq = irq_next;
  endtask

  function automatic logic [NC*RW-1:0] model_cfg();
    logic [NC*RW-1:0] p;
    for (int i = 0; i < NC; i++) p[i*RW +: RW] = m_cfg[i];
    return p;
  endfunction

  initial begin
    // Hand-derived sequence: en w r addr wdata ev -> rdata irq
    tbl[0]  = mk(1,0,1, 1, 8'h00, 4'h0, 8'hA5, 0);
    tbl[1]  = mk(1,0,1, 0, 8'h00, 4'h0, 8'h00, 0);
    tbl[2]  = mk(1,0,1,12, 8'h00, 4'h0, 8'h00, 0);
    tbl[3]  = mk(1,0,1,13, 8'h00, 4'h0, 8'h00, 0);
    tbl[4]  = mk(1,1,0, 2, 8'hFF, 4'h0, 8'h00, 0);
    tbl[5]  = mk(1,0,1, 2, 8'h00, 4'h0, 8'h5F, 0);
    tbl[6]  = mk(1,0,1, 9, 8'h00, 4'h0, 8'h3C, 0);
    tbl[7]  = mk(1,1,0, 9, 8'hAA, 4'h0, 8'h3C, 0);
    tbl[8]  = mk(1,0,1,12, 8'h00, 4'h0, 8'h80, 0);
    tbl[9]  = mk(1,0,1, 0, 8'h00, 4'h0, 8'h00, 0);
    tbl[10] = mk(1,1,0,12, 8'h80, 4'h0, 8'h00, 0);
    tbl[11] = mk(1,0,1,15, 8'h00, 4'h0, 8'h00, 0);
    tbl[12] = mk(1,0,1,12, 8'h00, 4'h0, 8'h80, 0);
    tbl[13] = mk(1,1,0,12, 8'h80, 4'h0, 8'h80, 0);
    tbl[14] = mk(1,1,0,13, 8'h01, 4'h0, 8'h80, 0);
    tbl[15] = mk(1,0,0, 0, 8'h00, 4'h1, 8'h80, 0);
    tbl[16] = mk(1,0,0, 0, 8'h00, 4'h0, 8'h80, 1);
    tbl[17] = mk(1,0,1,12, 8'h00, 4'h0, 8'h01, 1);
    tbl[18] = mk(1,0,0, 0, 8'h00, 4'h1, 8'h01, 1);
    tbl[19] = mk(1,1,0,12, 8'h01, 4'h1, 8'h01, 1);
    tbl[20] = mk(1,0,0, 0, 8'h00, 4'h1, 8'h01, 0);
    tbl[21] = mk(1,0,1,12, 8'h00, 4'h1, 8'h00, 0);
    tbl[22] = mk(1,0,0, 0, 8'h00, 4'h0, 8'h00, 0);
    tbl[23] = mk(1,1,0,12, 8'h04, 4'h4, 8'h00, 0);
    tbl[24] = mk(1,0,1,12, 8'h00, 4'h4, 8'h04, 0);
    tbl[25] = mk(1,1,0,12, 8'h04, 4'h0, 8'h04, 0);
    tbl[26] = mk(1,1,1, 0, 8'h3C, 4'h0, 8'h00, 0);
    tbl[27] = mk(1,0,1, 0, 8'h00, 4'h0, 8'h3C, 0);
    tbl[28] = mk(0,1,0, 0, 8'h77, 4'h0, 8'h3C, 0);
    tbl[29] = mk(0,0,1,15, 8'h00, 4'h0, 8'h3C, 0);
    tbl[30] = mk(0,0,0, 0, 8'h00, 4'h8, 8'h3C, 0);
    tbl[31] = mk(1,0,1, 0, 8'h00, 4'h0, 8'h3C, 0);
    tbl[32] = mk(1,0,1,12, 8'h00, 4'h0, 8'h08, 0);
    tbl[33] = mk(1,1,0,13, 8'hFF, 4'h0, 8'h08, 0);
    tbl[34] = mk(1,0,0, 0, 8'h00, 4'h0, 8'h08, 1);
    tbl[35] = mk(1,0,1,13, 8'h00, 4'h0, 8'h8F, 1);
    tbl[36] = mk(1,1,0,13, 8'h00, 4'h0, 8'h8F, 1);
    tbl[37] = mk(1,0,0, 0, 8'h00, 4'h0, 8'h8F, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cfg", 64'(config_regs), 64'(CRST));
    check("reset_rdata", 64'(rdata), 64'h0);
    check("reset_irq", 64'(irq), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 38; i++) begin
      apply(tbl[i].en, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].ev);
      $display("vec %0d en=%b we=%b re=%b addr=%0d wdata=%h ev=%h -> rdata=%h irq=%b",
               i, tbl[i].en, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].ev, rdata, irq);
      check($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(tbl[i].ex_rd));
      check($sformatf("vec%0d_irq", i), 64'(irq), 64'(tbl[i].ex_irq));
    end
    check("cfg_after_vectors", 64'(config_regs), 64'h0000_0000_005F_A53C);

    // Asynchronous reset: takes effect mid-cycle, before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_cfg", 64'(config_regs), 64'(CRST));
    check("async_reset_rdata", 64'(rdata), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 300; n++) begin
      logic          r_en, r_w, r_r;
      logic [AW-1:0] r_a;
      logic [RW-1:0] r_d;
      logic [NE-1:0] r_ev;
      r_en = ($urandom_range(0, 9) != 0);
      r_w  = $urandom_range(0, 1);
      r_r  = $urandom_range(0, 1);
      r_a  = AW'($urandom_range(0, 15));
      r_d  = RW'($urandom);
      r_ev = ($urandom_range(0, 3) == 0) ? NE'($urandom) : event_in;
      status_regs = 32'($urandom);
      model_step(r_en, r_w, r_r, int'(r_a), r_d, r_ev, status_regs);
      apply(r_en, r_w, r_r, r_a, r_d, r_ev);
      $display("rnd %0d en=%b we=%b re=%b addr=%0d wdata=%h ev=%h -> rdata=%h irq=%b",
               n, r_en, r_w, r_r, r_a, r_d, r_ev, rdata, irq);
      check($sformatf("rnd%0d_rdata", n), 64'(rdata), 64'(m_rd));
      check($sformatf("rnd%0d_irq", n), 64'(irq), 64'(m_irq));
      check($sformatf("rnd%0d_cfg", n), 64'(config_regs), 64'(model_cfg()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
